// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and constants for the adder sequencer slice.
// State encoding, seven-segment codes and the blank pattern.
package adder_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ADD,
        SHOW
    } state_t;

    localparam logic [6:0] HEX_BLANK = 7'b1111111;

    // Active-low {g..a} codes for digits 0..9
    localparam logic [6:0] SEG_CODES [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg7(input logic [3:0] d);
        if (d > 4'd9) return HEX_BLANK;
        return SEG_CODES[d];
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Operand/result bundle between the sequencer and the external
// ripple adder; the sequencer is master, the adder is slave.
interface adder_seq_ctrl_if;

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [5:0] add_sum;

    modport master (
        output add_a, add_b, add_cin,
        input  add_sum
    );

    modport slave (
        input  add_a, add_b, add_cin,
        output add_sum
    );

endinterface

// File: rtl/adder_seq_ctrl_debounce.sv
// Two-flop synchronizer plus debounce counter for an active-low key.
// Emits a one-cycle press pulse once per accepted press.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level_n;
    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Level flips only after a full run of samples disagreeing with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            level_n <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == level_n) begin
                cnt <= '0;
            end else if (last) begin
                cnt     <= '0;
                level_n <= sync[1];
                press   <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Board-side sequencer for the 4-bit ripple adder: operand capture,
// settle wait, result register and decimal display. ADDER_ACCUM_EN adds chaining.
module adder_seq_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic                     CLOCK_50,
    input  logic                     rst_n,
    input  logic [17:0]              SW,
    input  logic [1:0]               KEY,
    adder_seq_ctrl_if.master         add,
    output logic [17:0]              LEDR,
    output logic [6:0]               HEX0,
    output logic [6:0]               HEX1,
    output logic                     busy
);

    localparam int unsigned SC_W =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [1:0]      rst_q;
    logic            rst_sync_n;
    logic            ev_enter, ev_clear;
    state_t          state, state_d;
    logic [3:0]      a_q, b_q;
    logic            cin_q;
    logic [5:0]      result;
    logic [SC_W-1:0] settle;
    logic            settle_last;
    logic            load_a, load_b, capture, accum_load;
    logic            ovf_bit;
    logic [3:0]      st_led;
    logic [4:0]      sat, base;
    logic [1:0]      tens;
    logic [3:0]      units;
    logic            show;
    wire             unused_sw = ^{SW[17:9], SW[7:4]};

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_sync_n = rst_q[1];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(CLOCK_50), .rst_n(rst_sync_n), .key_n(KEY[0]), .press(ev_enter)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(CLOCK_50), .rst_n(rst_sync_n), .key_n(KEY[1]), .press(ev_clear)
    );

    assign settle_last = (settle == SC_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= IDLE;
        else             state <= state_d;
    end

    always_comb begin
        state_d    = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        capture    = 1'b0;
        accum_load = 1'b0;
        if (ev_clear) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE:   if (ev_enter) state_d = LOAD_A;
                LOAD_A: if (ev_enter) begin
                    load_a  = 1'b1;
                    state_d = LOAD_B;
                end
                LOAD_B: if (ev_enter) begin
                    load_b  = 1'b1;
                    state_d = ADD;
                end
                ADD: if (settle_last) begin
                    capture = 1'b1;
                    state_d = SHOW;
                end
                SHOW: if (ev_enter) begin
`ifdef ADDER_ACCUM_EN
                    accum_load = 1'b1;
                    state_d    = LOAD_B;
`else
                    state_d    = LOAD_A;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            result <= '0;
            settle <= '0;
        end else if (ev_clear) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            result <= '0;
            settle <= '0;
        end else begin
            if (load_a)     a_q <= SW[3:0];
            if (accum_load) a_q <= result[3:0];
            if (load_b) begin
                b_q   <= SW[3:0];
                cin_q <= SW[8];
            end
            if (state == ADD) settle <= settle_last ? '0 : settle + 1'b1;
            if (capture)      result <= add.add_sum;
        end
    end

`ifdef ADDER_ACCUM_EN
    logic ovf;
    always_ff @(posedge CLOCK_50 or negedge rst_sync_n) begin
        if (!rst_sync_n)                       ovf <= 1'b0;
        else if (ev_clear)                     ovf <= 1'b0;
        else if (capture && add.add_sum[5:4] != 2'b00) ovf <= 1'b1;
    end
    assign ovf_bit = ovf;
`else
    assign ovf_bit = 1'b0;
`endif

    assign add.add_a   = a_q;
    assign add.add_b   = b_q;
    assign add.add_cin = cin_q;
    assign busy        = (state == ADD);

    always_comb begin
        st_led = 4'b0000;
        case (state)
            LOAD_A:  st_led = 4'b0001;
            LOAD_B:  st_led = 4'b0010;
            ADD:     st_led = 4'b0100;
            SHOW:    st_led = 4'b1000;
            default: st_led = 4'b0000;
        endcase
    end

    assign LEDR = {1'b0, ovf_bit, st_led, 6'b000000, result};

    // Decimal split by compare chain; display value saturates at 31
    always_comb begin
        sat  = (result > 6'd31) ? 5'd31 : result[4:0];
        tens = 2'd0;
        base = 5'd0;
        if (sat >= 5'd30) begin
            tens = 2'd3;
            base = 5'd30;
        end else if (sat >= 5'd20) begin
            tens = 2'd2;
            base = 5'd20;
        end else if (sat >= 5'd10) begin
            tens = 2'd1;
            base = 5'd10;
        end
        units = 4'(sat - base);
    end

    assign show = (state == ADD) || (state == SHOW);
    assign HEX0 = show ? seg7(units) : HEX_BLANK;
    assign HEX1 = (show && tens != 2'd0) ? seg7({2'b00, tens}) : HEX_BLANK;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: behavioural reference model checked every
// cycle, directed board scenarios, then randomized key/switch traffic.
module tb_adder_seq_ctrl;

    localparam int N = 4;
    localparam int S = 2;
    localparam logic [1:0] ENTER = 2'b10;
    localparam logic [1:0] CLEAR = 2'b01;
    localparam logic [1:0] BOTH  = 2'b00;
    localparam logic [1:0] NONE  = 2'b11;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n    = 1'b1;
    logic [17:0] SW       = '0;
    logic [1:0]  KEY      = 2'b11;
    logic [17:0] LEDR;
    logic [6:0]  HEX0, HEX1;
    logic        busy;

    adder_seq_ctrl_if bus ();

    assign bus.add_sum = 6'(bus.add_a) + 6'(bus.add_b) + 6'(bus.add_cin);

    adder_seq_ctrl #(.DEBOUNCE_CYCLES(N), .SETTLE_CYCLES(S)) dut (
        .CLOCK_50(CLOCK_50),
        .rst_n(rst_n),
        .SW(SW),
        .KEY(KEY),
        .add(bus.master),
        .LEDR(LEDR),
        .HEX0(HEX0),
        .HEX1(HEX1),
        .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int busy_cycles = 0;

    logic [6:0] seg_t [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000
    };

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 load A, 2 load B, 3 adding, 4 showing
    int   m_phase, m_a, m_b, m_cin, m_res, m_left, m_hold;
    bit   m_ovf;
    bit [1:0] m_lvl, m_pend, m_d1, m_d2, m_ev;
    bit   hq0[$];
    bit   hq1[$];

    function automatic bit all_eq(input bit q[$], input bit x);
        if (q.size() < N) return 1'b0;
        foreach (q[i]) if (q[i] != x) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_a = 0; m_b = 0; m_cin = 0; m_res = 0;
            m_left = 0; m_ovf = 0; m_hold = 0;
            m_lvl = 2'b11; m_pend = 2'b00; m_d1 = 2'b11; m_d2 = 2'b11;
            hq0.delete(); hq1.delete();
        end else if (m_hold < 2) begin
            m_hold++;
        end else begin
            m_ev = m_pend;
            m_pend = 2'b00;
            // key k's debounced view lags the pin by two samples
            hq0.push_back(m_d2[0]);
            hq1.push_back(m_d2[1]);
            if (hq0.size() > N) void'(hq0.pop_front());
            if (hq1.size() > N) void'(hq1.pop_front());
            if (m_d2[0] != m_lvl[0] && all_eq(hq0, m_d2[0])) begin
                m_lvl[0] = m_d2[0];
                m_pend[0] = !m_d2[0];
            end
            if (m_d2[1] != m_lvl[1] && all_eq(hq1, m_d2[1])) begin
                m_lvl[1] = m_d2[1];
                m_pend[1] = !m_d2[1];
            end
            m_d2 = m_d1;
            m_d1 = KEY;
            if (m_ev[1]) begin
                m_phase = 0; m_a = 0; m_b = 0; m_cin = 0;
                m_res = 0; m_left = 0; m_ovf = 0;
            end else if (m_phase == 0) begin
                if (m_ev[0]) m_phase = 1;
            end else if (m_phase == 1) begin
                if (m_ev[0]) begin m_a = int'(SW[3:0]); m_phase = 2; end
            end else if (m_phase == 2) begin
                if (m_ev[0]) begin
                    m_b = int'(SW[3:0]); m_cin = int'(SW[8]);
                    m_phase = 3; m_left = S;
                end
            end else if (m_phase == 3) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = m_a + m_b + m_cin;
                    if (m_res >= 16) m_ovf = 1;
                    m_phase = 4;
                end
            end else if (m_ev[0]) begin
`ifdef ADDER_ACCUM_EN
                m_a = m_res % 16;
                m_phase = 2;
`else
                m_phase = 1;
`endif
            end
        end
    end

    logic [17:0] e_ledr;
    logic [6:0]  e_hex0, e_hex1;
    int          e_v;

    always @(negedge CLOCK_50) begin
        if (busy === 1'b1) busy_cycles++;
        if (chk_en) begin
            e_ledr = 18'(m_res);
            if (m_phase > 0) e_ledr[11 + m_phase] = 1'b1;
`ifdef ADDER_ACCUM_EN
            e_ledr[16] = m_ovf;
`endif
            e_v = (m_res > 31) ? 31 : m_res;
            e_hex0 = BLANK;
            e_hex1 = BLANK;
            if (m_phase >= 3) begin
                e_hex0 = seg_t[e_v % 10];
                if (e_v >= 10) e_hex1 = seg_t[e_v / 10];
            end
            check("ledr", 32'(LEDR), 32'(e_ledr));
            check("hex0", 32'(HEX0), 32'(e_hex0));
            check("hex1", 32'(HEX1), 32'(e_hex1));
            check("busy", 32'(busy), 32'(m_phase == 3));
            check("add_a", 32'(bus.add_a), 32'(m_a));
            check("add_b", 32'(bus.add_b), 32'(m_b));
            check("add_cin", 32'(bus.add_cin), 32'(m_cin));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] k, input int cyc);
        KEY = k;
        repeat (cyc) @(negedge CLOCK_50);
    endtask

    task automatic press(input logic [1:0] k, input logic [17:0] sw);
        SW = sw;
        drive(k, N + 2);
        drive(NONE, N + 4);
    endtask

    task automatic run_sum(input int a, input int b, input int cin);
        press(ENTER, 18'h0);
        press(ENTER, 18'(a));
        press(ENTER, 18'(b) | (18'(cin) << 8));
    endtask

    int r;
    bit seen;

    initial begin
        #3 rst_n = 1'b0;
        #1;
        check("rst_ledr", 32'(LEDR), 32'h0);
        check("rst_hex0", 32'(HEX0), 32'(BLANK));
        check("rst_hex1", 32'(HEX1), 32'(BLANK));
        check("rst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        // 7 + 9 + 1 = 17
        busy_cycles = 0;
        run_sum(7, 9, 1);
        check("s17_busy_cycles", 32'(busy_cycles), 32'd2);
        check("s17_result", 32'(LEDR[5:0]), 32'd17);
        check("s17_state", 32'(LEDR[15:12]), 32'b1000);
        check("s17_hex1", 32'(HEX1), 32'(7'b1111001));
        check("s17_hex0", 32'(HEX0), 32'(7'b1111000));

        // 15 + 15 + 1 = 31
        press(CLEAR, 18'h0);
        run_sum(15, 15, 1);
        check("s31_result", 32'(LEDR[5:0]), 32'd31);
        check("s31_hex1", 32'(HEX1), 32'(7'b0110000));
        check("s31_hex0", 32'(HEX0), 32'(7'b1111001));

        // bouncy enter advances exactly one step
        press(CLEAR, 18'h0);
        press(ENTER, 18'h0);
        SW = 18'h5;
        drive(ENTER, 3);
        drive(NONE, 1);
        drive(ENTER, 6);
        drive(NONE, N + 4);
        check("bounce_state", 32'(LEDR[15:12]), 32'b0010);
        check("bounce_a", 32'(bus.add_a), 32'h5);

        // enter and clear together in LOAD_B: clear wins
        busy_cycles = 0;
        press(BOTH, 18'h1A);
        check("both_state", 32'(LEDR[15:12]), 32'b0000);
        check("both_a", 32'(bus.add_a), 32'h0);
        check("both_no_add", 32'(busy_cycles), 32'd0);

        // reset asserted while adding
        press(ENTER, 18'h0);
        press(ENTER, 18'h3);
        SW = 18'h4;
        drive(ENTER, N + 2);
        KEY = NONE;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (busy === 1'b1) seen = 1'b1;
            else @(negedge CLOCK_50);
        end
        check("add_reached", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ledr", 32'(LEDR), 32'h0);
        check("mid_rst_hex0", 32'(HEX0), 32'(BLANK));
        check("mid_rst_hex1", 32'(HEX1), 32'(BLANK));
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_a", 32'(bus.add_a), 32'h0);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        // 9 + 9 = 18
        run_sum(9, 9, 0);
        check("s18_result", 32'(LEDR[5:0]), 32'd18);
        check("s18_hex1", 32'(HEX1), 32'(7'b1111001));
        check("s18_hex0", 32'(HEX0), 32'(7'b0000000));
`ifdef ADDER_ACCUM_EN
        check("s18_ovf", 32'(LEDR[16]), 32'd1);
        press(ENTER, 18'h0);
        check("acc_a", 32'(bus.add_a), 32'h2);
        check("acc_state", 32'(LEDR[15:12]), 32'b0010);
        press(ENTER, 18'h8);
        check("acc_result", 32'(LEDR[5:0]), 32'd10);
        check("acc_hex0", 32'(HEX0), 32'(7'b1000000));
`else
        check("s18_ovf", 32'(LEDR[16]), 32'd0);
        press(ENTER, 18'h0);
        check("show_to_a", 32'(LEDR[15:12]), 32'b0001);
`endif

        // randomized key and switch traffic
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            SW = 18'($urandom);
            if (r < 65) begin
                press(ENTER, 18'($urandom));
            end else if (r < 75) begin
                press(CLEAR, 18'($urandom));
            end else if (r < 80) begin
                press(BOTH, 18'($urandom));
            end else if (r < 90) begin
                drive(ENTER, $urandom_range(1, N - 1));
                drive(NONE, $urandom_range(1, N + 2));
            end else begin
                drive(ENTER, $urandom_range(N, N + 5));
                drive(NONE, $urandom_range(N, N + 6));
            end
        end
        drive(NONE, 2 * N + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
